// File: rtl/segre_csr_unit.sv
// Supervisor-mode CSR unit: sparse CSR map, trap entry/SRET stacking, vectored STVEC,
// cycle/instret counters and illegal-access detection.
module segre_csr_unit #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          CSR_SIZE  = 12,
    parameter int unsigned          CNT_WIDTH = 64,
    parameter logic [WORD_SIZE-1:0] SATP_RST  = 32'h0000_8000,
    parameter logic [WORD_SIZE-1:0] STVEC_RST = 32'h0000_2000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 re_i,
    input  logic [CSR_SIZE-1:0]  raddr_i,
    output logic [WORD_SIZE-1:0] data_o,
    input  logic                 we_i,
    input  logic [CSR_SIZE-1:0]  waddr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    output logic                 illegal_o,
    input  logic                 retire_i,
    input  logic                 exc_valid_i,
    input  logic [WORD_SIZE-1:0] exc_cause_i,
    input  logic [WORD_SIZE-1:0] exc_pc_i,
    input  logic [WORD_SIZE-1:0] exc_tval_i,
    input  logic                 sret_i,
    output logic                 trap_taken_o,
    output logic [WORD_SIZE-1:0] redirect_pc_o,
    output logic                 sie_o,
    output logic [WORD_SIZE-1:0] csr_satp_o,
    output logic [1:0]           csr_priv_o
);
    typedef logic [CSR_SIZE-1:0] addr_t;

    localparam bit          HAS_HI     = (CNT_WIDTH == 2 * WORD_SIZE);
    localparam int unsigned XW         = (WORD_SIZE < 9) ? 9 : WORD_SIZE;
    localparam addr_t       A_SSTATUS  = addr_t'(12'h100);
    localparam addr_t       A_STVEC    = addr_t'(12'h105);
    localparam addr_t       A_SSCRATCH = addr_t'(12'h140);
    localparam addr_t       A_SEPC     = addr_t'(12'h141);
    localparam addr_t       A_SCAUSE   = addr_t'(12'h142);
    localparam addr_t       A_STVAL    = addr_t'(12'h143);
    localparam addr_t       A_SATP     = addr_t'(12'h180);
    localparam addr_t       A_PRIV     = addr_t'(12'h5C0);
    localparam addr_t       A_CYCLE    = addr_t'(12'hC00);
    localparam addr_t       A_INSTRET  = addr_t'(12'hC02);
    localparam addr_t       A_CYCLEH   = addr_t'(12'hC80);
    localparam addr_t       A_INSTRETH = addr_t'(12'hC82);
    localparam addr_t       A_SPACE_LO = addr_t'(12'h100);
    localparam addr_t       A_SPACE_HI = addr_t'(12'h5FF);

    logic                 sie_q, spie_q, spp_q;
    logic [1:0]           priv_q;
    logic [WORD_SIZE-1:0] stvec_q, sscratch_q, sepc_q, scause_q, stval_q, satp_q;
    logic [CNT_WIDTH-1:0] cycle_q, instret_q;

    function automatic logic is_mapped(input addr_t a);
        case (a)
            A_SSTATUS, A_STVEC, A_SSCRATCH, A_SEPC, A_SCAUSE, A_STVAL,
            A_SATP, A_PRIV, A_CYCLE, A_INSTRET: is_mapped = 1'b1;
            A_CYCLEH, A_INSTRETH:               is_mapped = HAS_HI;
            default:                            is_mapped = 1'b0;
        endcase
    endfunction

    function automatic logic is_ro(input addr_t a);
        is_ro = (a == A_CYCLE) || (a == A_INSTRET) || (a == A_CYCLEH) || (a == A_INSTRETH);
    endfunction

    function automatic logic needs_smode(input addr_t a);
        needs_smode = (a >= A_SPACE_LO) && (a <= A_SPACE_HI);
    endfunction

    logic          umode, r_bad, w_bad, csr_wr, is_irq;
    logic [XW-1:0] wdata_x, sstatus_x;

    // SSTATUS fields sit up to bit 8, so they are staged through a view at least 9 bits wide.
    assign wdata_x   = XW'(data_i);
    assign sstatus_x = XW'({spp_q, 2'b00, spie_q, 3'b000, sie_q, 1'b0});

    assign umode     = (priv_q == 2'b00);
    assign r_bad     = ~is_mapped(raddr_i) | (umode & needs_smode(raddr_i));
    assign w_bad     = ~is_mapped(waddr_i) | is_ro(waddr_i) | (umode & needs_smode(waddr_i));
    assign illegal_o = (re_i & r_bad) | (we_i & w_bad);
    assign csr_wr    = we_i & ~w_bad;

    assign is_irq       = exc_cause_i[WORD_SIZE-1];
    assign trap_taken_o = exc_valid_i & (~is_irq | umode | sie_q);

    assign sie_o      = sie_q;
    assign csr_satp_o = satp_q;
    assign csr_priv_o = priv_q;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no path can infer a latch.
        data_o = '0;
        case (raddr_i)
            A_SSTATUS:  data_o = WORD_SIZE'(sstatus_x);
            A_STVEC:    data_o = stvec_q;
            A_SSCRATCH: data_o = sscratch_q;
            A_SEPC:     data_o = sepc_q;
            A_SCAUSE:   data_o = scause_q;
            A_STVAL:    data_o = stval_q;
            A_SATP:     data_o = satp_q;
            A_PRIV:     data_o = WORD_SIZE'(priv_q);
            A_CYCLE:    data_o = cycle_q[WORD_SIZE-1:0];
            A_INSTRET:  data_o = instret_q[WORD_SIZE-1:0];
            A_CYCLEH:   if (HAS_HI) data_o = cycle_q[CNT_WIDTH-1 -: WORD_SIZE];
            A_INSTRETH: if (HAS_HI) data_o = instret_q[CNT_WIDTH-1 -: WORD_SIZE];
            default:    data_o = '0;
        endcase
    end

    always_comb begin
        redirect_pc_o = '0;
        if (trap_taken_o) begin
            redirect_pc_o = {stvec_q[WORD_SIZE-1:2], 2'b00};
            // Vectored mode: interrupts jump to base + 4*cause, wrapping at the PC width.
            if (stvec_q[1:0] == 2'b01 && is_irq)
                redirect_pc_o = {stvec_q[WORD_SIZE-1:2], 2'b00}
                              + {exc_cause_i[WORD_SIZE-3:0], 2'b00};
        end else if (sret_i) begin
            redirect_pc_o = sepc_q;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            sie_q      <= 1'b1;
            spie_q     <= 1'b0;
            spp_q      <= 1'b1;
            priv_q     <= 2'b01;
            satp_q     <= SATP_RST;
            stvec_q    <= STVEC_RST;
            sscratch_q <= '0;
            sepc_q     <= '0;
            scause_q   <= '0;
            stval_q    <= '0;
            cycle_q    <= '0;
            instret_q  <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_WIDTH'(1);
            if (retire_i) instret_q <= instret_q + CNT_WIDTH'(1);

            // Trap beats SRET beats CSR write; the losers are simply dropped.
            if (trap_taken_o) begin
                sepc_q   <= exc_pc_i;
                scause_q <= exc_cause_i;
                stval_q  <= exc_tval_i;
                spie_q   <= sie_q;
                sie_q    <= 1'b0;
                spp_q    <= priv_q[0];
                priv_q   <= 2'b01;
            end else if (sret_i) begin
                sie_q  <= spie_q;
                spie_q <= 1'b1;
                priv_q <= {1'b0, spp_q};
                spp_q  <= 1'b0;
            end else if (csr_wr) begin
                case (waddr_i)
                    A_SSTATUS: begin
                        sie_q  <= wdata_x[1];
                        spie_q <= wdata_x[5];
                        spp_q  <= wdata_x[8];
                    end
                    A_STVEC:    stvec_q    <= data_i;
                    A_SSCRATCH: sscratch_q <= data_i;
                    A_SEPC:     sepc_q     <= {data_i[WORD_SIZE-1:2], 2'b00};
                    A_SCAUSE:   scause_q   <= data_i;
                    A_STVAL:    stval_q    <= data_i;
                    A_SATP:     satp_q     <= data_i;
                    A_PRIV:     priv_q     <= data_i[1:0];
                    default:    ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_segre_csr_unit.sv
// Directed self-checking bench for segre_csr_unit: reset, traps, SRET, masking, vectoring,
// illegal accesses, priority and counters (a narrow instance covers the low/high carry).
module tb_segre_csr_unit;
    logic        clk_i = 1'b0;
    logic        rst_i, re_i, we_i, retire_i, exc_valid_i, sret_i;
    logic [11:0] raddr_i, waddr_i;
    logic [31:0] data_i, exc_cause_i, exc_pc_i, exc_tval_i;
    logic [31:0] data_o, redirect_pc_o, csr_satp_o;
    logic        illegal_o, trap_taken_o, sie_o;
    logic [1:0]  csr_priv_o;

    // Narrow instance: 8-bit words, 16-bit counters.
    logic        s_rst, s_retire;
    logic [11:0] s_raddr;
    logic [7:0]  s_data_o, s_redirect, s_satp;
    logic        s_illegal, s_trap, s_sie;
    logic [1:0]  s_priv;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    segre_csr_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .re_i(re_i), .raddr_i(raddr_i), .data_o(data_o),
        .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i), .illegal_o(illegal_o),
        .retire_i(retire_i), .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i),
        .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i), .sret_i(sret_i),
        .trap_taken_o(trap_taken_o), .redirect_pc_o(redirect_pc_o), .sie_o(sie_o),
        .csr_satp_o(csr_satp_o), .csr_priv_o(csr_priv_o)
    );

    segre_csr_unit #(
        .WORD_SIZE(8), .CSR_SIZE(12), .CNT_WIDTH(16), .SATP_RST(8'h80), .STVEC_RST(8'h20)
    ) dut_small (
        .clk_i(clk_i), .rst_i(s_rst), .re_i(1'b0), .raddr_i(s_raddr), .data_o(s_data_o),
        .we_i(1'b0), .waddr_i(12'h000), .data_i(8'h00), .illegal_o(s_illegal),
        .retire_i(s_retire), .exc_valid_i(1'b0), .exc_cause_i(8'h00),
        .exc_pc_i(8'h00), .exc_tval_i(8'h00), .sret_i(1'b0),
        .trap_taken_o(s_trap), .redirect_pc_o(s_redirect), .sie_o(s_sie),
        .csr_satp_o(s_satp), .csr_priv_o(s_priv)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        re_i    = 1'b1;
        raddr_i = a;
        #1;
        check(tag, data_o, exp);
        re_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        data_i  = d;
        step();
        we_i = 1'b0;
    endtask

    task automatic clear_trap();
        exc_valid_i = 1'b0;
        sret_i      = 1'b0;
        we_i        = 1'b0;
        re_i        = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; s_rst = 1'b1; s_retire = 1'b0; s_raddr = 12'h000;
        re_i = 1'b0; we_i = 1'b0; retire_i = 1'b0; exc_valid_i = 1'b0; sret_i = 1'b0;
        raddr_i = '0; waddr_i = '0; data_i = '0;
        exc_cause_i = '0; exc_pc_i = '0; exc_tval_i = '0;
        step();
        step();
        rst_i = 1'b0; s_rst = 1'b0;

        // Reset state
        #1;
        check("rst_satp", csr_satp_o, 32'h8000);
        check("rst_sie", sie_o, 1'b1);
        check("rst_priv", csr_priv_o, 2'd1);
        check("rst_redirect", redirect_pc_o, 32'h0);
        check("rst_trap", trap_taken_o, 1'b0);
        rd("rst_stvec", 12'h105, 32'h2000);
        rd("rst_sstatus", 12'h100, 32'h102);
        rd("rst_cycle", 12'hC00, 32'h0);
        rd("rst_cycleh", 12'hC80, 32'h0);
        step();
        rd("cycle_plus1", 12'hC00, 32'h1);

        // Synchronous exception
        exc_valid_i = 1'b1; exc_cause_i = 32'h5; exc_pc_i = 32'h1234; exc_tval_i = 32'hDEAD;
        #1;
        check("exc_taken", trap_taken_o, 1'b1);
        check("exc_redirect", redirect_pc_o, 32'h2000);
        step();
        clear_trap();
        rd("exc_sepc", 12'h141, 32'h1234);
        rd("exc_scause", 12'h142, 32'h5);
        rd("exc_stval", 12'h143, 32'hDEAD);
        rd("exc_sstatus", 12'h100, 32'h120);
        check("exc_sie", sie_o, 1'b0);
        check("exc_priv", csr_priv_o, 2'd1);

        // SRET
        sret_i = 1'b1;
        #1;
        check("sret_redirect", redirect_pc_o, 32'h1234);
        check("sret_no_trap", trap_taken_o, 1'b0);
        step();
        clear_trap();
        #1;
        check("sret_sie", sie_o, 1'b1);
        check("sret_priv", csr_priv_o, 2'd1);
        rd("sret_sstatus", 12'h100, 32'h22);

        // Masked interrupt in S-mode with SIE=0
        wr(12'h100, 32'h0);
        check("mask_sie0", sie_o, 1'b0);
        exc_valid_i = 1'b1; exc_cause_i = 32'h8000_0005; exc_pc_i = 32'h9999;
        #1;
        check("mask_not_taken", trap_taken_o, 1'b0);
        check("mask_redirect", redirect_pc_o, 32'h0);
        step();
        clear_trap();
        rd("mask_sepc", 12'h141, 32'h1234);
        rd("mask_scause", 12'h142, 32'h5);

        // Vectored STVEC
        wr(12'h105, 32'h3001);
        wr(12'h100, 32'h2);
        rd("vec_stvec", 12'h105, 32'h3001);
        check("vec_sie1", sie_o, 1'b1);
        exc_valid_i = 1'b1; exc_cause_i = 32'h2;
        #1;
        check("vec_sync_base", redirect_pc_o, 32'h3000);
        exc_cause_i = 32'h8000_0005; exc_pc_i = 32'h4000; exc_tval_i = 32'h0;
        #1;
        check("vec_irq_taken", trap_taken_o, 1'b1);
        check("vec_irq_redirect", redirect_pc_o, 32'h3014);
        step();
        clear_trap();
        rd("vec_scause", 12'h142, 32'h8000_0005);
        rd("vec_sepc", 12'h141, 32'h4000);
        rd("vec_sstatus", 12'h100, 32'h120);

        // Illegal accesses
        we_i = 1'b1; waddr_i = 12'hC00; data_i = 32'h12345;
        #1;
        check("ill_wr_cycle", illegal_o, 1'b1);
        waddr_i = 12'hC02;
        #1;
        check("ill_wr_instret", illegal_o, 1'b1);
        step();
        we_i = 1'b0;
        rd("ill_instret_kept", 12'hC02, 32'h0);
        re_i = 1'b1; raddr_i = 12'h7FF;
        #1;
        check("ill_unmapped_data", data_o, 32'h0);
        check("ill_unmapped_flag", illegal_o, 1'b1);
        re_i = 1'b0;
        #1;
        check("ill_idle", illegal_o, 1'b0);
        wr(12'h5C0, 32'h0);
        check("umode_priv", csr_priv_o, 2'd0);
        re_i = 1'b1; raddr_i = 12'h141;
        #1;
        check("ill_umode_sepc", illegal_o, 1'b1);
        raddr_i = 12'hC00;
        #1;
        check("umode_cycle_ok", illegal_o, 1'b0);
        re_i = 1'b0;
        we_i = 1'b1; waddr_i = 12'h140; data_i = 32'h55;
        #1;
        check("ill_umode_wr", illegal_o, 1'b1);
        step();
        we_i = 1'b0;

        // Interrupt from U-mode is taken even with SIE=0
        exc_valid_i = 1'b1; exc_cause_i = 32'h8000_0003; exc_pc_i = 32'h6000; exc_tval_i = 32'h0;
        #1;
        check("umode_irq_taken", trap_taken_o, 1'b1);
        check("umode_irq_redirect", redirect_pc_o, 32'h300C);
        step();
        clear_trap();
        #1;
        check("umode_trap_priv", csr_priv_o, 2'd1);
        rd("umode_trap_sstatus", 12'h100, 32'h0);
        rd("ill_wr_no_effect", 12'h140, 32'h0);

        // Priority: trap > sret > write
        exc_valid_i = 1'b1; exc_cause_i = 32'h7; exc_pc_i = 32'h5000; exc_tval_i = 32'h1;
        sret_i = 1'b1; we_i = 1'b1; waddr_i = 12'h141; data_i = 32'hAAAA;
        #1;
        check("prio_taken", trap_taken_o, 1'b1);
        check("prio_redirect", redirect_pc_o, 32'h3000);
        step();
        clear_trap();
        rd("prio_sepc", 12'h141, 32'h5000);
        rd("prio_stval", 12'h143, 32'h1);
        rd("prio_sstatus", 12'h100, 32'h100);
        sret_i = 1'b1; we_i = 1'b1; waddr_i = 12'h140; data_i = 32'h77;
        #1;
        check("prio_sret_redirect", redirect_pc_o, 32'h5000);
        step();
        clear_trap();
        rd("prio_sret_drops_wr", 12'h140, 32'h0);
        check("prio_sret_priv", csr_priv_o, 2'd1);
        check("prio_sret_sie", sie_o, 1'b0);
        rd("prio_sret_sstatus", 12'h100, 32'h20);

        // Same-cycle write/read returns the old value
        we_i = 1'b1; waddr_i = 12'h140; data_i = 32'h1111;
        rd("rw_old_value", 12'h140, 32'h0);
        step();
        we_i = 1'b0;
        rd("rw_new_value", 12'h140, 32'h1111);
        wr(12'h141, 32'h1237);
        rd("sepc_align", 12'h141, 32'h1234);
        wr(12'h180, 32'hABCD);
        check("satp_out", csr_satp_o, 32'hABCD);

        // Counters: instret counting and reset mid-count
        retire_i = 1'b1;
        repeat (3) step();
        retire_i = 1'b0;
        rd("instret_3", 12'hC02, 32'h3);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        rd("rst_mid_cycle", 12'hC00, 32'h0);
        rd("rst_mid_instret", 12'hC02, 32'h0);
        rd("rst_mid_instreth", 12'hC82, 32'h0);
        check("rst_mid_satp", csr_satp_o, 32'h8000);

        // Low-to-high carry on the narrow instance
        s_retire = 1'b1;
        repeat (255) step();
        s_raddr = 12'hC02;
        #1;
        check("carry_lo_ff", s_data_o, 8'hFF);
        s_raddr = 12'hC82;
        #1;
        check("carry_hi_0", s_data_o, 8'h00);
        step();
        s_retire = 1'b0;
        #1;
        check("carry_hi_1", s_data_o, 8'h01);
        s_raddr = 12'hC02;
        #1;
        check("carry_lo_0", s_data_o, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
